// File: rtl/easydram_bram_pkg.sv
// -----------------------------------------------------------------------------
// easydram_bram_pkg
//   Shared helpers for the EasyDRAM BRAM-backed queues.
//   - addr_width() : address width for a BRAM of a given depth
//   - lvl_width()  : occupancy counter width (BRAM entries + output buffer + 0)
//   - ptr_wrap()   : pointer increment that wraps at depth-1 by explicit compare,
//                    so depths that are not a power of two work correctly
// -----------------------------------------------------------------------------
package easydram_bram_pkg;

    // Entries held in the read-side output buffer behind the BRAM.
    localparam int OUT_BUF_ENTRIES = 2;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lvl_width(input int depth);
        return $clog2(depth + OUT_BUF_ENTRIES + 1);
    endfunction

    function automatic int ptr_wrap(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/bram_fifo_out_buf.sv
// -----------------------------------------------------------------------------
// bram_fifo_out_buf
//   Two-entry valid/ready buffer placed after the BRAM read port. It absorbs the
//   one-cycle BRAM read latency so the queue can stream at one entry per cycle.
//
//   clk_i        in   clock (posedge)
//   rst_ni       in   asynchronous active-low reset
//   clr_i        in   synchronous clear; wins over push/pop
//   push_i       in   write push_data_i into the buffer
//   push_data_i  in   DATA_WIDTH payload
//   pop_i        in   consumer takes the head entry
//   head_data_o  out  head entry payload (reset/clear value 0)
//   head_valid_o out  head entry present
//   cnt_o        out  entries held (0..2)
// -----------------------------------------------------------------------------
module bram_fifo_out_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_valid_o,
    output logic [1:0]            cnt_o
);

    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  pop_eff;
    logic                  tail_load;

    assign pop_eff   = pop_i & (cnt_q != 2'd0);
    // The tail only receives data when the head stays occupied after this cycle.
    assign tail_load = push_i & (((cnt_q == 2'd1) & ~pop_eff) | ((cnt_q == 2'd2) & pop_eff));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push_i) begin
                        head_q <= push_data_i;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_eff) begin
                        head_q <= push_data_i;
                    end else if (push_i) begin
                        cnt_q <= 2'd2;
                    end else if (pop_eff) begin
                        cnt_q <= 2'd0;
                    end
                end
                default: begin
                    // Full: the fetch logic upstream never pushes without a pop here.
                    if (pop_eff) begin
                        head_q <= tail_q;
                        cnt_q  <= push_i ? 2'd2 : 2'd1;
                    end
                end
            endcase
        end
    end

    // Payload-only register; its contents are meaningless while cnt_q < 2.
    always_ff @(posedge clk_i) begin
        if (tail_load) begin
            tail_q <= push_data_i;
        end
    end

    assign head_data_o  = head_q;
    assign head_valid_o = (cnt_q != 2'd0);
    assign cnt_o        = cnt_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
//   Valid/ready FIFO controller in front of a dual-port byte-masked BRAM.
//   BRAM port 0 is write-only, port 1 read-only with a one-cycle registered read.
//   A two-entry output buffer hides the read latency. Capacity BRAM_DEPTH + 2.
//
//   clk_i / rst_ni             clock, asynchronous active-low reset
//   flush_i                    synchronous clear of all entries (highest priority)
//   wr_valid_i/wr_ready_o/wr_data_i   producer side
//   rd_valid_o/rd_ready_i/rd_data_o   consumer side
//   level_o                    registered entry count (BRAM + in flight + buffer)
//   bram_p0_*                  BRAM write port (data, addr, mask, wr_en, cmd_en)
//   bram_p1_*                  BRAM read port (addr, wr_en, cmd_en, data_i)
// -----------------------------------------------------------------------------
module bram_fifo_ctrl
    import easydram_bram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BRAM_DEPTH = 128,
    localparam int ADDR_WIDTH = addr_width(BRAM_DEPTH),
    localparam int LVL_WIDTH  = lvl_width(BRAM_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [LVL_WIDTH-1:0]    level_o,
    output logic [DATA_WIDTH-1:0]   bram_p0_data_o,
    output logic [ADDR_WIDTH-1:0]   bram_p0_addr_o,
    output logic [DATA_WIDTH/8-1:0] bram_p0_mask_o,
    output logic                    bram_p0_wr_en_o,
    output logic                    bram_p0_cmd_en_o,
    output logic [ADDR_WIDTH-1:0]   bram_p1_addr_o,
    output logic                    bram_p1_wr_en_o,
    output logic                    bram_p1_cmd_en_o,
    input  logic [DATA_WIDTH-1:0]   bram_p1_data_i
);

    localparam logic [LVL_WIDTH-1:0] MEM_FULL = LVL_WIDTH'(BRAM_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [LVL_WIDTH-1:0]  mem_cnt_q;
    logic [LVL_WIDTH-1:0]  level_q;
    logic                  inflight_vld_p1;

    logic                  accept;
    logic                  pop;
    logic                  fetch_p0;
    logic [1:0]            out_cnt;
    logic [2:0]            buf_occ;
    logic                  buf_room;

    // ---- fetch stage (p0): handshakes, BRAM read issue ----
    assign wr_ready_o = (mem_cnt_q != MEM_FULL);
    assign accept     = wr_valid_i & wr_ready_o & ~flush_i;
    assign pop        = rd_valid_o & rd_ready_i;

    // A fetch is allowed when the buffer will still have a free slot for the
    // read data next cycle, counting the entry already in flight and a pop now.
    assign buf_occ  = {1'b0, out_cnt} + {2'b00, inflight_vld_p1};
    assign buf_room = (buf_occ < (3'd2 + {2'b00, pop}));
    assign fetch_p0 = (mem_cnt_q != '0) & buf_room & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            mem_cnt_q       <= '0;
            level_q         <= '0;
            inflight_vld_p1 <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            mem_cnt_q       <= '0;
            level_q         <= '0;
            inflight_vld_p1 <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= ADDR_WIDTH'(ptr_wrap(int'(wr_ptr_q), BRAM_DEPTH));
            end
            if (fetch_p0) begin
                rd_ptr_q <= ADDR_WIDTH'(ptr_wrap(int'(rd_ptr_q), BRAM_DEPTH));
            end
            mem_cnt_q       <= mem_cnt_q + LVL_WIDTH'(accept) - LVL_WIDTH'(fetch_p0);
            // Fetch and capture only move entries between places; the total
            // changes solely with accepts and pops.
            level_q         <= level_q + LVL_WIDTH'(accept) - LVL_WIDTH'(pop);
            inflight_vld_p1 <= fetch_p0;
        end
    end

    // ---- capture stage (p1): BRAM read data into the output buffer ----
    bram_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (flush_i),
        .push_i       (inflight_vld_p1),
        .push_data_i  (bram_p1_data_i),
        .pop_i        (pop),
        .head_data_o  (rd_data_o),
        .head_valid_o (rd_valid_o),
        .cnt_o        (out_cnt)
    );

    assign level_o          = level_q;

    assign bram_p0_data_o   = wr_data_i;
    assign bram_p0_addr_o   = wr_ptr_q;
    assign bram_p0_mask_o   = '1;
    assign bram_p0_wr_en_o  = 1'b1;
    assign bram_p0_cmd_en_o = accept;

    assign bram_p1_addr_o   = rd_ptr_q;
    assign bram_p1_wr_en_o  = 1'b0;
    assign bram_p1_cmd_en_o = fetch_p0;

endmodule
